// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a
// maskable interrupt request; one-shot (Mode 00) or auto-reload (Mode 01).
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    // state | meaning
    // IDLE  | waiting for CTRL.En
    // LOAD  | COUNT <= PRESET
    // CNT   | decrementing COUNT
    // INT   | terminal reached; one-shot clears En, auto-reload drops the flag
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'b00;
    localparam logic [1:0] OFF_PRESET = 2'b01;
    localparam logic [1:0] OFF_COUNT  = 2'b10;
    localparam logic [1:0] MODE_AUTO  = 2'b01;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic        unused_addr_bits;

    assign sel              = Addr[3:2];
    assign wr_ctrl          = WE && (sel == OFF_CTRL);
    assign wr_preset        = WE && (sel == OFF_PRESET);
    assign ctrl_en          = ctrl_q[0];
    assign ctrl_mode        = ctrl_q[2:1];
    assign ctrl_im          = ctrl_q[3];
    assign unused_addr_bits = ^Addr[31:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 4'h0;
            preset_q   <= 32'h0;
            count_q    <= 32'h0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (wr_ctrl)   ctrl_d   = Din[3:0];
        if (wr_preset) preset_d = Din;
        // Any CTRL/PRESET write acknowledges a pending interrupt; the FSM below
        // may still set the flag in the same cycle and that takes precedence.
        if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                state_d = ST_IDLE;
                if (ctrl_mode == MODE_AUTO) begin
                    irq_flag_d = 1'b0;
                end else if (!wr_ctrl) begin
                    ctrl_d[0] = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (sel)
            OFF_CTRL:   Dout = {28'h0, ctrl_q};
            OFF_PRESET: Dout = preset_q;
            OFF_COUNT:  Dout = count_q;
            default:    Dout = 32'h0;
        endcase
    end

    assign IRQ = ctrl_im & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Randomized + directed bench for timer_counter: a reference model predicts each
// cycle's read data and IRQ into a queue, a negedge monitor pops and compares.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the timer seen as phases of a countdown "run".
    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_RUN = 2, PH_FIRE = 3;
    logic [31:0] m_ctrl, m_preset, m_count;
    logic        m_flag;
    int          m_phase;
    logic [31:0] base;

    task automatic model_reset();
        m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = PH_IDLE;
    endtask

    task automatic model_edge(input bit we, input int off, input logic [31:0] din);
        logic [31:0] c, p, n;
        int          ph;
        bit          en;
        int          mode;
        c = m_ctrl; p = m_preset; n = m_count; ph = m_phase;
        en   = c[0];
        mode = int'(c[2:1]);
        if (we && off == 0) m_ctrl = din & 32'hF;
        if (we && off == 1) m_preset = din;
        if (we && off < 2)  m_flag = 0;
        if (ph == PH_IDLE) begin
            if (en) m_phase = PH_ARMED;
        end else if (ph == PH_ARMED) begin
            m_count = p;
            m_phase = PH_RUN;
        end else if (ph == PH_RUN) begin
            if (!en) m_phase = PH_IDLE;
            else if (n > 1) m_count = n - 1;
            else begin
                m_count = 0; m_flag = 1; m_phase = PH_FIRE;
            end
        end else begin
            m_phase = PH_IDLE;
            if (mode == 1) m_flag = 0;
            else if (!(we && off == 0)) m_ctrl = m_ctrl & ~32'h1;
        end
    endtask

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0: return m_ctrl;
            1: return m_preset;
            2: return m_count;
            default: return 32'h0;
        endcase
    endfunction

    task automatic push_exp(input int off, input string tag);
        exp_t e;
        e.d   = model_read(off);
        e.irq = m_ctrl[3] & m_flag;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic drive_addr(input int off);
        logic [31:0] ba;
        ba   = base + 32'(off * 4);
        Addr = ba[31:2];
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cyc(input bit we, input int off, input logic [31:0] din, input string tag);
        WE = we; Din = din;
        drive_addr(off);
        push_exp(off, tag);
        @(posedge clk);
        model_edge(we, off, din);
        #1;
    endtask

    task automatic wr(input int off, input logic [31:0] v, input string tag);
        cyc(1'b1, off, v, tag);
    endtask

    task automatic rd(input int off, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, off, 32'h0, tag);
    endtask

    // Reset asserted between edges, held two cycles, released away from an edge.
    task automatic pulse_reset(input int off, input string tag);
        WE = 1'b0; Din = 32'h0;
        drive_addr(off);
        #2 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            push_exp(off, tag);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (Dout !== e.d || IRQ !== e.irq) begin
                bad++;
                $display("FAIL %s: got Dout=%h IRQ=%b, want Dout=%h IRQ=%b",
                         e.tag, Dout, IRQ, e.d, e.irq);
            end
        end
    end

    initial begin
        logic [31:0] v;
        int          off;
        int          guard;
        base  = 32'h7f00;
        reset = 1'b1; WE = 1'b0; Din = 32'h0;
        drive_addr(0);
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive_addr(i);
            push_exp(i, "reset_state");
            @(posedge clk); #1;
        end
        reset = 1'b0;

        // register map edges
        wr(2, 32'hFFFF_FFFF, "count_ro_wr");
        rd(2, 1, "count_ro");
        wr(3, 32'hFFFF_FFFF, "rsvd_wr");
        rd(3, 1, "rsvd_read");
        wr(0, 32'hFFFF_FFFF, "ctrl_wide_wr");
        rd(0, 1, "ctrl_width");
        wr(0, 32'h0, "ctrl_off");
        rd(2, 3, "settle");
        wr(1, 32'hFFFF_FFFF, "preset_max");
        wr(0, 32'h1, "en_max");
        rd(2, 5, "max_decrement");
        wr(0, 32'h0, "stop_max");

        // one-shot
        wr(1, 32'd5, "os_preset");
        wr(0, 32'h9, "os_enable");
        rd(2, 8, "os_count");
        rd(0, 2, "os_ctrl_after");
        rd(2, 20, "os_irq_hold");
        wr(1, 32'd3, "os_ack");
        rd(0, 3, "os_irq_dropped");

        // auto-reload
        base = 32'h7f10;
        wr(1, 32'd5, "ar_preset");
        wr(0, 32'hB, "ar_enable");
        rd(0, 36, "ar_pulses");
        wr(0, 32'h0, "ar_stop");
        rd(2, 3, "ar_settle");

        // masking
        wr(1, 32'd2, "mask_preset");
        wr(0, 32'h1, "mask_enable");
        rd(2, 8, "mask_terminal");
        wr(0, 32'h8, "mask_unmask");
        rd(0, 4, "mask_flag_cleared");

        // pause / resume: stop so COUNT settles at 6
        wr(1, 32'd10, "pr_preset");
        wr(0, 32'h9, "pr_enable");
        guard = 0;
        while (!(m_phase == PH_RUN && m_count == 32'd7) && guard < 40) begin
            rd(2, 1, "pr_run");
            guard++;
        end
        if (guard >= 40) begin
            bad++; total++;
            $display("FAIL pr_reach7: got guard=%0d, want count 7 before 40", guard);
        end
        wr(0, 32'h8, "pr_pause");
        rd(2, 6, "pr_frozen");
        wr(0, 32'h9, "pr_resume");
        rd(2, 4, "pr_reload");
        wr(0, 32'h0, "pr_stop");
        wr(1, 32'h0, "pr_ack");

        // reset mid-count
        wr(1, 32'd100, "rst_preset");
        wr(0, 32'h9, "rst_enable");
        rd(2, 10, "rst_running");
        pulse_reset(2, "rst_async");
        rd(2, 6, "rst_after_count");
        rd(0, 4, "rst_after_ctrl");

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset($urandom_range(0, 3), "rnd_reset");
            end else if ($urandom_range(0, 9) < 3) begin
                off = $urandom_range(0, 3);
                v   = $urandom;
                if (off == 1) begin
                    if ($urandom_range(0, 15) == 0) v = 32'hFFFF_FFFF;
                    else v = $urandom_range(0, 12);
                end
                if (off == 0 && $urandom_range(0, 3) == 0) v = 32'h0;
                wr(off, v, "rnd_write");
            end else begin
                rd($urandom_range(0, 3), 1, "rnd_read");
            end
            if ($urandom_range(0, 99) == 0) base = (base == 32'h7f00) ? 32'h7f10 : 32'h7f00;
        end

        WE = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            bad++; total++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped timer/counter peripheral on the CPU's peripheral bus.
- Acts as the responder for the bridge's timer windows; two instances sit at the base addresses 0x7f00 and 0x7f10.
- Decodes word-address writes and reads for three registers, runs a down-counter state machine, and raises an interrupt request to the CP0 interrupt inputs.

Parameters:
- None. Register map and widths are fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- Addr  input  30  word address [31:2]; only Addr[3:2] decoded
- WE  input  1  full-word write enable, already qualified by address window
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr[3:2]
- IRQ  output  1  interrupt request, level, registered-source

Behaviour:
- Register map, selected by Addr[3:2]:
  - 00 CTRL (R/W): bit0 En, bits2:1 Mode, bit3 IM (interrupt mask). Bits31:4 read 0; writes to them are ignored.
  - 01 PRESET (R/W, 32 bit).
  - 10 COUNT (read-only; writes ignored).
  - 11 reserved: reads 0, writes ignored.
- Reset:
  - CTRL, PRESET, COUNT, irq_flag all 0; state IDLE; Dout=0; IRQ=0.
  - Reset acts immediately and asynchronously, including mid-count or during INT.
- IRQ = CTRL.IM & irq_flag (combinational from registers).
- State machine (2-bit state):
  - IDLE: if CTRL.En=1 go to LOAD; else stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If CTRL.En=0, go to IDLE; COUNT holds.
    - Else if COUNT>1, COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1): COUNT <= 0; irq_flag <= 1; go to INT.
  - INT:
    - Mode 00, or any Mode other than 01: hardware clears CTRL.En; go to IDLE; irq_flag holds.
    - Mode 01 (auto-reload): CTRL.En untouched; irq_flag <= 0; go to IDLE, which reloads.
- irq_flag clearing:
  - Mode 00: irq_flag stays 1 until any bus write to CTRL or PRESET, which clears it at that edge.
  - Mode 01: cleared automatically after the one-cycle INT state.
- Write semantics:
  - Bus writes take effect at the edge where WE=1.
  - A bus write to CTRL in the same cycle as the hardware En clear in INT wins; the written value is stored.
  - A PRESET write never reloads COUNT directly; the new value is used at the next LOAD.
  - Clearing En while in CNT freezes COUNT and returns to IDLE.
  - Re-enabling from IDLE restarts from PRESET.
- Timing, Mode 00, with PRESET=N≥1 and CTRL written with En=1 at edge E:
  - LOAD at E+1.
  - COUNT=N after E+2.
  - COUNT=0, irq_flag=1 after E+N+2.
- Timing, Mode 01: interrupt period is N+3 cycles, with irq_flag high for exactly 1 cycle per period.
- PRESET=0 or 1: behaves as N=1; the interrupt comes one cycle after LOAD.
- Arithmetic: 32-bit unsigned decrement. No wrap below 0; COUNT saturates at 0 on terminal.
- Dout reads reflect register state before the current edge; there is no read side effect.

Test Plan:
- Reset mid-count:
  - Stimulus: PRESET=100, Mode 00, running; assert reset for 2 cycles between edges.
  - Response: IRQ, COUNT, CTRL and Dout go to 0 immediately; state IDLE; no interrupt after reset release.
- Mode 00 one-shot:
  - Stimulus: PRESET=5; write CTRL=0x9 (En, IM) at edge E.
  - Response: COUNT reads 5 after E+2 and 1 after E+6; IRQ goes to 1 after E+7; CTRL reads 0x8; IRQ remains 1 for 20 further cycles.
  - Stimulus: then write PRESET=3.
  - Response: IRQ drops at that edge.
- Mode 01 auto-reload:
  - Stimulus: PRESET=5; CTRL=0xB.
  - Response: IRQ is a single-cycle pulse every 8 cycles for at least 4 periods; CTRL.En stays 1.
- Masking:
  - Stimulus: Mode 00, PRESET=2, CTRL=0x1 (IM=0).
  - Response: IRQ stays 0 at terminal count.
  - Stimulus: then write CTRL=0x8.
  - Response: IRQ stays 0, because the write clears irq_flag.
- Pause and resume:
  - Stimulus: PRESET=10, CTRL=0x9; write CTRL=0x8 when COUNT=6.
  - Response: COUNT frozen at 6 for 5 cycles; no IRQ.
  - Stimulus: rewrite CTRL=0x9.
  - Response: COUNT reloads to 10 two edges later.
- Register map edges:
  - Stimulus: write 0xFFFFFFFF to CTRL, COUNT and offset 11 while disabled.
  - Response: CTRL reads 0xF; COUNT reads unchanged; offset 11 reads 0; PRESET boundary 0xFFFFFFFF loads and decrements to 0xFFFFFFFE.
